// File: rtl/alsu_cmd_driver.sv
// Issuing side of the ALSU operand/control interface: buffers packed commands,
// drives the ALSU pins, tracks in-flight tokens and collects results into a response FIFO.
module alsu_cmd_driver #(
  parameter int unsigned ALSU_LAT  = 2,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [14:0]      cmd_data,
  input  logic             cmd_dir,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_out,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             alsu_rst,
  output logic [2:0]       alsu_A,
  output logic [2:0]       alsu_B,
  output logic [2:0]       alsu_opcode,
  output logic             alsu_cin,
  output logic             alsu_serial_in,
  output logic             alsu_red_op_A,
  output logic             alsu_red_op_B,
  output logic             alsu_bypass_A,
  output logic             alsu_bypass_B,
  output logic             alsu_direction,
  input  logic [5:0]       alsu_out,
  input  logic [15:0]      alsu_leds,
  output logic [7:0]       err_count
);

  localparam int unsigned CAW   = $clog2(CMD_DEPTH);
  localparam int unsigned RAW   = $clog2(RSP_DEPTH);
  localparam int unsigned CMD_W = 16 + TAG_W;
  localparam int unsigned RSP_W = 7 + TAG_W;
  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + ALSU_LAT + 2) + 1;

  typedef enum logic [1:0] {ST_HOLD, ST_WAKE, ST_RUN} state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW:0]     cmd_wr, cmd_rd;
  logic             cmd_full, cmd_empty, cmd_push;
  logic [CMD_W-1:0] head;
  logic             head_dir;
  logic [14:0]      head_data;
  logic [TAG_W-1:0] head_tag;

  logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW:0]     rsp_wr, rsp_rd, rsp_count;
  logic             rsp_pop, capture;

  logic [ALSU_LAT:0] pipe_v;
  logic [TAG_W-1:0]  pipe_tag [ALSU_LAT+1];
  logic [OCC_W-1:0]  inflight, occupancy;
  logic              issue;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_HOLD;
    else      state <= state_nxt;
  end

  // The ALSU is held in reset for one extra cycle after rst releases.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: state_nxt = ST_WAKE;
      ST_WAKE: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_HOLD;
    endcase
    alsu_rst = (state != ST_RUN);
  end

  assign cmd_full  = (cmd_wr[CAW] != cmd_rd[CAW]) && (cmd_wr[CAW-1:0] == cmd_rd[CAW-1:0]);
  assign cmd_empty = (cmd_wr == cmd_rd);
  assign cmd_ready = (state != ST_HOLD) && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  assign head      = cmd_mem[cmd_rd[CAW-1:0]];
  assign head_dir  = head[CMD_W-1];
  assign head_data = head[TAG_W +: 15];
  assign head_tag  = head[TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr[CAW-1:0]] <= {cmd_dir, cmd_data, cmd_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_wr <= '0;
      cmd_rd <= '0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
      if (issue)    cmd_rd <= cmd_rd + 1'b1;
    end
  end

  assign rsp_count = rsp_wr - rsp_rd;
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign capture   = pipe_v[ALSU_LAT];

  // A same-cycle pop frees its slot in time for the token issued now,
  // which keeps one command per cycle flowing while rsp_ready is high.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= ALSU_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_v[i]);
    end
    occupancy = OCC_W'(rsp_count) + inflight - OCC_W'(rsp_pop);
    issue     = !cmd_empty && (state == ST_RUN) && (occupancy < OCC_W'(RSP_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst && issue) begin
      alsu_A         <= head_data[14:12];
      alsu_B         <= head_data[11:9];
      alsu_opcode    <= head_data[8:6];
      alsu_cin       <= head_data[5];
      alsu_serial_in <= head_data[4];
      alsu_red_op_A  <= head_data[3];
      alsu_red_op_B  <= head_data[2];
      alsu_bypass_A  <= head_data[1];
      alsu_bypass_B  <= head_data[0];
      alsu_direction <= head_dir;
    end else begin
      alsu_A         <= '0;
      alsu_B         <= '0;
      alsu_opcode    <= '0;
      alsu_cin       <= 1'b0;
      alsu_serial_in <= 1'b0;
      alsu_red_op_A  <= 1'b0;
      alsu_red_op_B  <= 1'b0;
      alsu_bypass_A  <= 1'b0;
      alsu_bypass_B  <= 1'b0;
      alsu_direction <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pipe_v <= '0;
    else      pipe_v <= {pipe_v[ALSU_LAT-1:0], issue};
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= head_tag;
    for (int unsigned i = 1; i <= ALSU_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) rsp_mem[rsp_wr[RAW-1:0]] <= {alsu_out, |alsu_leds, pipe_tag[ALSU_LAT]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      err_count <= '0;
    end else begin
      if (capture) rsp_wr <= rsp_wr + 1'b1;
      if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
      if (capture && (|alsu_leds) && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    {rsp_out, rsp_err, rsp_tag} = '0;
    if (rsp_valid) {rsp_out, rsp_err, rsp_tag} = rsp_mem[rsp_rd[RAW-1:0]];
  end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Scoreboard bench for alsu_cmd_driver with a behavioural two-stage ALSU stub
// and an expected-response queue computed from the command fields.
module tb_alsu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [14:0] cmd_data;
  logic [3:0]  cmd_tag;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [5:0]  rsp_out;
  logic [3:0]  rsp_tag;
  logic        alsu_rst;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic [7:0]  err_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [10:0] exp_q [$];
  int          exp_err  = 0;
  logic        rnd_ready  = 1'b0;
  logic        ready_hold = 1'b1;

  alsu_cmd_driver #(.ALSU_LAT(2), .CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .alsu_rst(alsu_rst), .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_direction(alsu_direction),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference ALSU behaviour: returns {error, out}.
  function automatic logic [6:0] ref_rsp(input logic [14:0] d, input logic dir);
    logic [2:0] a, b, op;
    logic       cin, sin, ra, rb, ba, bb;
    logic [5:0] v;
    {a, b, op, cin, sin, ra, rb, ba, bb} = d;
    v = {b, a};
    if (op >= 3'd6 || ((ra || rb) && op > 3'd1)) return {1'b1, 6'd0};
    if (ba) return {4'b0, a};
    if (bb) return {4'b0, b};
    case (op)
      3'd0:    return {1'b0, ra ? {5'd0, &a} : rb ? {5'd0, &b} : {3'd0, a & b}};
      3'd1:    return {1'b0, ra ? {5'd0, ^a} : rb ? {5'd0, ^b} : {3'd0, a ^ b}};
      3'd2:    return {1'b0, 6'(int'(a) + int'(b) + int'(cin))};
      3'd3:    return {1'b0, 6'(int'(a) * int'(b))};
      3'd4:    return {1'b0, dir ? {v[4:0], sin} : {sin, v[5:1]}};
      default: return {1'b0, dir ? {v[4:0], v[5]} : {v[0], v[5:1]}};
    endcase
  endfunction

  function automatic logic [14:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic cin,
                                     input logic ba, input logic bb);
    return {a, b, op, cin, 1'b0, 1'b0, 1'b0, ba, bb};
  endfunction

  // ALSU stub: input register then output register, reset by alsu_rst.
  logic [14:0] s_d;
  logic        s_dir;
  logic [6:0]  s_r;
  always @(posedge clk) begin
    if (alsu_rst) begin
      s_d       <= '0;
      s_dir     <= 1'b0;
      alsu_out  <= '0;
      alsu_leds <= '0;
    end else begin
      s_d   <= {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
                alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};
      s_dir <= alsu_direction;
      s_r = ref_rsp(s_d, s_dir);
      alsu_out  <= s_r[5:0];
      alsu_leds <= s_r[6] ? 16'hFFFF : 16'h0000;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // rsp_ready is changed only here, shortly after the rising edge.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = rnd_ready ? (($urandom & 1) != 0) : ready_hold;
    end
  end

  task automatic set_ready(input logic v);
    ready_hold = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: the head must match the scoreboard front; it pops on handshake.
  initial begin
    logic [10:0] cur, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rsp_valid === 1'b1) begin
        cur = {rsp_out, rsp_err, rsp_tag};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got %0h with empty scoreboard at %0t", cur, $time);
        end else if (rsp_ready) begin
          e = exp_q.pop_front();
          chk("rsp", 32'(cur), 32'(e));
        end else begin
          chk("rsp_head_hold", 32'(cur), 32'(exp_q[0]));
        end
      end
    end
  end

  task automatic send(input logic [14:0] d, input logic dir, input logic [3:0] tag);
    int unsigned n;
    logic [6:0]  r;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_tag   = tag;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL send_timeout: cmd_ready 0 expected 1 within 200 cycles, tag %0h", tag);
    end else begin
      r = ref_rsp(d, dir);
      exp_q.push_back({r[5:0], r[6], tag});
      if (r[6] && exp_err < 255) exp_err++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
  endtask

  task automatic pins_idle(input string name);
    chk(name, {22'd0, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
               alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction}, 0);
  endtask

  initial begin
    int unsigned k;
    logic        seen;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_tag = '0;

    repeat (3) @(negedge clk);
    chk("reset_alsu_rst", 32'(alsu_rst), 1);
    chk("reset_cmd_ready", 32'(cmd_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", {21'd0, rsp_out, rsp_err, rsp_tag}, 0);
    chk("reset_err_count", 32'(err_count), 0);
    pins_idle("reset_pins");

    rst = 1'b1;
    @(negedge clk);
    chk("wake_alsu_rst", 32'(alsu_rst), 1);
    chk("wake_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    chk("run_alsu_rst", 32'(alsu_rst), 0);

    // single add, measure acceptance-to-valid latency
    send(mk(3'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0), 1'b0, 4'd5);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 4);
    drain("drain_single");

    // opcodes 0..7 back to back
    for (int op = 0; op < 8; op++) send(mk(3'd2, 3'd3, 3'(op), 1'b0, 1'b0, 1'b0), 1'b0, 4'(op));
    drain("drain_opcodes");
    chk("err_count_opcodes", 32'(err_count), 2);

    // backpressure: 8 commands with consumer stalled
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) send(15'($urandom), 1'($urandom), 4'(8 + i));
    repeat (6) @(negedge clk);
    chk("bp_cmd_ready", 32'(cmd_ready), 0);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    pins_idle("bp_pins_idle");
    set_ready(1'b1);
    drain("drain_bp");
    chk("err_count_bp", 32'(err_count), 32'(exp_err));

    // bypass
    send(mk(3'd2, 3'd3, 3'($urandom_range(0, 5)), 1'b0, 1'b1, 1'b0), 1'b0, 4'd1);
    send(mk(3'd2, 3'd3, 3'($urandom_range(0, 5)), 1'b0, 1'b0, 1'b1), 1'b0, 4'd2);
    drain("drain_bypass");

    // random traffic with random consumer readiness
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(15'($urandom), 1'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_ready = 1'b0;
    set_ready(1'b1);
    drain("drain_random");
    chk("err_count_random", 32'(err_count), 32'(exp_err));

    // reset with commands in flight
    set_ready(1'b0);
    for (int i = 0; i < 3; i++) send(mk(3'd1, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0), 1'b0, 4'(i));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_err = 0;
    rst = 1'b1;
    ready_hold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("no_stale_rsp", 32'(seen), 0);
    chk("err_count_after_reset", 32'(err_count), 0);
    send(mk(3'd4, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0), 1'b0, 4'd9);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alsu_cmd_driver.md
Name: alsu_cmd_driver

Overview:
- Issuing end of the ALSU operand/control interface; sits between a command source and one ALSU instance.
- Accepts packed ALSU commands over valid/ready and buffers them in a command FIFO.
- Drives the ALSU input pins one command per cycle and tracks in-flight commands through the ALSU's fixed pipeline latency.
- Captures out/leds into a response FIFO returned over valid/ready, with an error flag for invalid-opcode responses.

Parameters:
- ALSU_LAT, 2, cycles from ALSU pins sampled to out/leds valid (input register plus output register).
- CMD_DEPTH, 4, command FIFO entries (power of 2).
- RSP_DEPTH, 4, response FIFO entries (power of 2, at least ALSU_LAT).
- TAG_W, 4, width of the command tag echoed with the response.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_data  in  15  {A[2:0],B[2:0],opcode[2:0],cin,serial_in,red_op_A,red_op_B,bypass_A,bypass_B}.
- cmd_dir  in  1  shift/rotate direction for this command.
- cmd_tag  in  TAG_W  returned with the result.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer accepts the head response.
- rsp_out  out  6  captured ALSU out.
- rsp_err  out  1  captured leds != 0.
- rsp_tag  out  TAG_W  tag of the originating command.
- alsu_rst  out  1  active-high ALSU reset.
- alsu_A, alsu_B, alsu_opcode  out  3 each  ALSU operand pins.
- alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each.
- alsu_out  in  6  ALSU result.
- alsu_leds  in  16  ALSU leds.
- err_count  out  8  saturating count of error responses.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Both FIFOs and the in-flight pipe are cleared.
  - All alsu_* operand pins are 0; alsu_rst=1.
  - rsp_valid=0; rsp_out, rsp_tag, rsp_err=0; err_count=0.
  - cmd_ready=0 during reset.
- Post-reset sequence:
  - alsu_rst stays 1 for exactly one cycle after the first edge with rst=1, then 0.
  - cmd_ready may assert from the first cycle after reset.
  - No issue occurs while alsu_rst=1.
- Command accept: a command is written when cmd_valid && cmd_ready.
  - cmd_ready = !cmd_full.
  - If the FIFO is full and the head pops in the same cycle, the cmd is still refused (cmd_ready is registered-state based).
- Issue condition: cmd FIFO not empty && !alsu_rst && credits > 0.
  - credits = RSP_DEPTH − rsp_count − inflight_count.
  - On issue the head is popped and its fields are registered onto the alsu_* pins for one cycle.
  - A valid bit and the tag are pushed into a pipe ALSU_LAT+1 deep. The pipe delay matches the pin register plus ALSU latency; alsu_out is sampled when the token exits.
  - Throughput: 1 command per cycle when unblocked.
- Idle cycles: alsu_* pins are driven to 0 (opcode AND, no bypass); no token is pushed.
- Capture: when a token exits the pipe, {alsu_out, |alsu_leds, tag} is written to the response FIFO.
  - Space is guaranteed by credits, so no overflow is possible.
  - err_count increments on each error capture and saturates at 255.
- Response handshake:
  - The head is presented on rsp_* while rsp_valid; it pops on rsp_valid && rsp_ready.
  - Data is stable while rsp_valid && !rsp_ready.
  - Simultaneous capture and pop is legal; rsp_count is unchanged.
- Backpressure: rsp_ready held 0 drains the credits; issue stops with exactly RSP_DEPTH responses buffered; no response is lost or reordered.
- Ordering: responses leave in command-accept order.
- Reset mid-operation drops all queued and in-flight commands; no stale response may appear after reset.

Test Plan:
- Reset release → alsu_rst high for exactly 1 cycle after rst rises; all outputs 0; cmd_ready=1 from the next cycle.
- Single cmd A=2,B=3,opcode=2 (add),cin=0,tag=5 → rsp_valid asserts ALSU_LAT+2 cycles after acceptance (pin register + ALSU_LAT + capture); rsp_out=5, rsp_tag=5, rsp_err=0.
- Back-to-back opcodes 0..7 with A=2,B=3, tags 0..7, rsp_ready=1 → 8 in-order responses; tags 6 and 7 have rsp_err=1; err_count=2.
- rsp_ready=0 with 8 cmds pushed → exactly 4 responses buffered, cmd FIFO holds the rest, cmd_ready=0 once full; releasing rsp_ready drains all 8 in order.
- bypass_A=1 then bypass_B=1 with A=2,B=3 → rsp_out=2 then 3.
- rst low while 3 cmds are in flight → after reset no rsp_valid until new cmds are issued; err_count=0.
